mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Parametrised sequential multiply/divide unit for the Mini-SRC datapath.
- Replaces the single-cycle combinational mul/div path in the ALU with an iterative engine.
- Writes a 2*WIDTH result into HI/LO-format outputs.
- The control unit starts it with a one-cycle pulse and waits for a done pulse before moving HI/LO onto the bus.
- Adds unsigned variants and a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand width in bits. Legal values are >= 4. The iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- clear  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  2  operation select: 00 MUL signed, 01 MULU unsigned, 10 DIV signed, 11 DIVU unsigned. Sampled with start.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; hi/lo/dbz valid from this cycle on.
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.
- dbz  output  1  last completed divide had b==0.

Behaviour:
- Reset: clear low forces the following immediately, without waiting for a clock edge:
  - state IDLE
  - busy=0, done=0, dbz=0
  - hi=0, lo=0
  - counter and internal operand/accumulator registers zeroed.
- Reset mid-operation aborts the operation. No done is produced for the aborted request.
- States: IDLE, RUN, FIX.
  - IDLE: on an edge with start=1, do all of the following, then go to RUN with busy=1:
    - latch op;
    - latch magnitudes of a and b (absolute value for signed ops, raw for unsigned);
    - latch result sign bits;
    - clear the accumulator;
    - load the counter with WIDTH.
  - RUN: one radix-2 iteration per edge; counter decrements.
    - MUL: shift-add. If the multiplier LSB is 1, add the multiplicand to the upper accumulator, then shift right by 1.
    - DIV: restoring. Shift {rem,quot} left by 1, trial-subtract the divisor from rem; if non-negative keep the difference and set the quot LSB, else restore.
    - Exactly WIDTH RUN edges, then go to FIX.
  - FIX: one edge, then go to IDLE with busy=0 and done=1 for that single following cycle. On this edge:
    - apply sign correction;
    - register hi/lo;
    - update dbz.
- Latency: if start is sampled at edge k, done=1 and results are valid after edge k+WIDTH+1. busy is high from edge k to edge k+WIDTH+1.
- Signed MUL: {hi,lo} is the two's-complement 2*WIDTH product. Negate if the operand signs differ.
- Unsigned MUL: {hi,lo} = a*b, full width, no overflow possible.
- Signed DIV: truncating division.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - a=MIN, b=-1 gives lo=MIN, hi=0 (wraps, no flag).
- Divide by zero (op[1]=1, b==0):
  - same latency as any other divide;
  - lo = all ones, hi = a as sampled, dbz=1 (regardless of signedness).
  - Any subsequent completed op clears dbz, including MUL.
- hi, lo and dbz hold their values between completions. They change only on a FIX edge or on reset.
- start while busy=1 is ignored: no queueing, operands not re-sampled.
- start asserted in the done cycle (state IDLE) is accepted: back-to-back operation, busy high again after that edge.
- op, a and b may change freely after the sampling edge.

Test Plan:
- WIDTH=32, MUL a=0xFFFFFFF9 (-7), b=6 → after exactly 33 cycles: done pulse of 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFD6, dbz=0.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Same operands with MUL (signed) → hi=0, lo=1.
- DIV a=-17, b=5 → lo=0xFFFFFFFD, hi=0xFFFFFFFE. DIVU a=17, b=5 → lo=3, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, dbz=1 after 33 cycles; a following MULU 3*4 → lo=12, hi=0, dbz=0.
- Handshake:
  - start pulses every cycle during busy are ignored (only one done, result of the first operands);
  - start in the done cycle → second done exactly 33 cycles later;
  - hi/lo stable between dones.
- Reset: drive clear low at cycle 10 of a DIVU → busy, done, hi, lo, dbz all 0 before the next edge, with no done afterwards. After clear is released, MULU 7*9 → lo=63.
- WIDTH=8 instance: MUL a=0x80, b=0x80 → hi=0x40, lo=0x00 after 9 cycles; DIVU a=200, b=7 → lo=28, hi=4.

Source files
------------

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_seq
//  Purpose  : Iterative radix-2 multiply/divide unit (signed/unsigned) with
//             HI/LO result registers and a divide-by-zero flag.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int            CW         = $clog2(WIDTH) + 1;
    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_RUN      = 2'd1;
    localparam logic [1:0]    c_FIX      = 2'd2;
    localparam logic [CW-1:0] c_CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_quo, w_rem;

    assign w_a_neg = ~op[0] & a[WIDTH-1];
    assign w_b_neg = ~op[0] & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // x holds multiplier (MUL) or dividend/quotient (DIV); y the other operand
    assign w_sum   = {1'b0, acc_q} + {1'b0, (x_q[0] ? y_q : {WIDTH{1'b0}})};
    assign w_shift = {acc_q, x_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, y_q};

    assign w_prod     = {acc_q, x_q};
    assign w_prod_fix = neg_quo_q ? -w_prod : w_prod;
    assign w_quo      = neg_quo_q ? -x_q : x_q;
    assign w_rem      = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        acc_d     = acc_q;
        araw_d    = araw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    op_d      = op;
                    x_d       = op[1] ? w_a_mag : w_b_mag;
                    y_d       = op[1] ? w_b_mag : w_a_mag;
                    acc_d     = '0;
                    cnt_d     = c_CNT_LOAD;
                    araw_d    = a;
                    neg_quo_d = w_a_neg ^ w_b_neg;
                    neg_rem_d = w_a_neg;
                    state_d   = c_RUN;
                end
            end
            c_RUN: begin
                cnt_d = cnt_q - c_CNT_LAST;
                if (!op_q[1]) begin
                    acc_d = w_sum[WIDTH:1];
                    x_d   = {w_sum[0], x_q[WIDTH-1:1]};
                end else if (!w_diff[WIDTH]) begin
                    acc_d = w_diff[WIDTH-1:0];
                    x_d   = {x_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = w_shift[WIDTH-1:0];
                    x_d   = {x_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == c_CNT_LAST) begin
                    state_d = c_FIX;
                end
            end
            c_FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = w_prod_fix;
                    dbz_d        = 1'b0;
                end else if (y_q == '0) begin
                    lo_d  = '1;
                    hi_d  = araw_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d  = w_quo;
                    hi_d  = w_rem;
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= c_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            acc_q     <= '0;
            araw_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            x_q       <= x_d;
            y_q       <= y_d;
            acc_q     <= acc_d;
            araw_q    <= araw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != c_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dbz  = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_seq
//  Purpose  : Directed self-checking bench for mdu_seq (WIDTH=32 and WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32)) u_dut32 (
        .clock(clk), .clear(clear), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
    );

    mdu_seq #(.WIDTH(8)) u_dut8 (
        .clock(clk), .clear(clear), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbz(dbz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1ns after an edge: presents a request, lets the next edge sample it
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz);
        int lat;
        @(posedge clk); #1;
        launch(o, x, y);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
    endtask

    task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int lat;
        @(posedge clk); #1;
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd9);
        check({tag, "_hi"}, 64'(hi8), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo8), 64'(exp_lo));
    endtask

    initial begin
        int lat;
        int nd;
        int chg;
        logic [31:0] hs, ls;

        clear = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;

        // Main function, WIDTH=32
        run32("mul_neg7x6", 2'b00, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        run32("mulu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run32("mul_m1m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        run32("div_m17_5", 2'b10, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run32("divu_17_5", 2'b11, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0);
        run32("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run32("div_by_zero", 2'b10, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("hold_hi", 64'(hi), 64'h1234);
        check("hold_dbz", 64'(dbz), 64'd1);
        run32("mulu_3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        // start pulses while busy are ignored
        @(posedge clk); #1;
        launch(2'b01, 32'd5, 32'd6);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1; op = 2'b01; a = 32'(7 + i); b = 32'd8;
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(lat);
        check("ign_lat", 64'(lat + 10), 64'd33);
        check("ign_lo", 64'(lo), 64'd30);
        hs = hi; ls = lo; nd = 0; chg = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) nd++;
            if (hi !== hs || lo !== ls) chg++;
        end
        check("ign_extra_done", 64'(nd), 64'd0);
        check("ign_stable", 64'(chg), 64'd0);

        // back-to-back: start in the done cycle
        run32("divu_100_0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        launch(2'b01, 32'd11, 32'd13);
        wait_done(lat);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_lo", 64'(lo), 64'd143);
        check("b2b_dbz", 64'(dbz), 64'd0);

        // reset in the middle of a divide
        run32("div_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        launch(2'b11, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 clear = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        check("mid_rst_dbz", 64'(dbz), 64'd0);
        @(posedge clk); #1 clear = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("mid_rst_no_done", 64'(nd), 64'd0);
        run32("mulu_7x9", 2'b01, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0);

        // WIDTH=8 instance
        run8("w8_mul_80x80", 2'b00, 8'h80, 8'h80, 8'h40, 8'h00);
        run8("w8_divu_200_7", 2'b11, 8'd200, 8'd7, 8'd4, 8'd28);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
